// File: rtl/contador_regressivo.sv
// BCD M:SS countdown timer (0:00-9:59) with one-step-per-DIV_TICK prescaler and expiry flags.
// Optional expiry alarm pulse is enabled by defining CONTADOR_ALARME_EN.
module contador_regressivo #(
    parameter int DIV_TICK = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Load,
    input  logic [3:0] LoadMin,
    input  logic [3:0] LoadDez,
    input  logic [3:0] LoadSeg,
    output logic [3:0] Minutos,
    output logic [3:0] DezenaSeg,
    output logic [3:0] Segundos,
    output logic       Rodando,
    output logic       Zero,
    output logic       Alarme
);

    localparam int PW = $clog2(DIV_TICK);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_TICK - 1);

    typedef enum logic [1:0] {PARADO, CONTANDO, PAUSADO, FIM} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    min_reg, min_next, dez_reg, dez_next, seg_reg, seg_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          tick, time_zero, dec_zero;
    logic [3:0]    min_ld, dez_ld, seg_ld;
    logic [3:0]    min_dec, dez_dec, seg_dec;
`ifdef CONTADOR_ALARME_EN
    logic          alarme_reg, alarme_next;
    logic [2:0]    alarm_cnt_reg, alarm_cnt_next;
`endif

    assign tick      = (presc_reg == PRESC_MAX);
    assign time_zero = (min_reg == 4'd0) && (dez_reg == 4'd0) && (seg_reg == 4'd0);
    assign min_ld    = (LoadMin > 4'd9) ? 4'd9 : LoadMin;
    assign dez_ld    = (LoadDez > 4'd5) ? 4'd5 : LoadDez;
    assign seg_ld    = (LoadSeg > 4'd9) ? 4'd9 : LoadSeg;

    // Borrow chain; only used when the current time is nonzero.
    always_comb begin
        seg_dec = seg_reg - 4'd1;
        dez_dec = dez_reg;
        min_dec = min_reg;
        if (seg_reg == 4'd0) begin
            seg_dec = 4'd9;
            if (dez_reg != 4'd0) begin
                dez_dec = dez_reg - 4'd1;
            end else begin
                dez_dec = 4'd5;
                min_dec = min_reg - 4'd1;
            end
        end
    end

    assign dec_zero = (min_dec == 4'd0) && (dez_dec == 4'd0) && (seg_dec == 4'd0);

    always_comb begin
        state_next = state_reg;
        min_next   = min_reg;
        dez_next   = dez_reg;
        seg_next   = seg_reg;
        presc_next = presc_reg;
`ifdef CONTADOR_ALARME_EN
        alarme_next    = alarme_reg;
        alarm_cnt_next = alarm_cnt_reg;
`endif
        case (state_reg)
            PARADO: begin
                if (Load) begin
                    min_next   = min_ld;
                    dez_next   = dez_ld;
                    seg_next   = seg_ld;
                    presc_next = '0;
                end else if (!Stop && Start && !time_zero) begin
                    state_next = CONTANDO;
                end
            end
            CONTANDO: begin
                if (Stop) begin
                    state_next = PAUSADO;
                end else begin
                    presc_next = tick ? '0 : presc_reg + 1'b1;
                    if (tick) begin
                        min_next = min_dec;
                        dez_next = dez_dec;
                        seg_next = seg_dec;
                        if (dec_zero) begin
                            state_next = FIM;
`ifdef CONTADOR_ALARME_EN
                            alarme_next    = 1'b1;
                            alarm_cnt_next = 3'd0;
`endif
                        end
                    end
                end
            end
            PAUSADO: begin
                if (Load) begin
                    state_next = PARADO;
                    min_next   = min_ld;
                    dez_next   = dez_ld;
                    seg_next   = seg_ld;
                    presc_next = '0;
                end else if (Stop) begin
                    state_next = PARADO;
                    min_next   = 4'd0;
                    dez_next   = 4'd0;
                    seg_next   = 4'd0;
                    presc_next = '0;
                end else if (Start && !time_zero) begin
                    state_next = CONTANDO;
                end
            end
            default: begin // FIM
                if (Load || Stop) begin
                    state_next = PARADO;
                    presc_next = '0;
                    if (Load) begin
                        min_next = min_ld;
                        dez_next = dez_ld;
                        seg_next = seg_ld;
                    end
`ifdef CONTADOR_ALARME_EN
                    alarme_next = 1'b0;
`endif
                end
`ifdef CONTADOR_ALARME_EN
                // Alarm lasts five prescaler periods after expiry.
                else if (alarme_reg) begin
                    presc_next = tick ? '0 : presc_reg + 1'b1;
                    if (tick) begin
                        if (alarm_cnt_reg == 3'd4) alarme_next = 1'b0;
                        else alarm_cnt_next = alarm_cnt_reg + 3'd1;
                    end
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= PARADO;
            min_reg   <= 4'd0;
            dez_reg   <= 4'd0;
            seg_reg   <= 4'd0;
            presc_reg <= '0;
`ifdef CONTADOR_ALARME_EN
            alarme_reg    <= 1'b0;
            alarm_cnt_reg <= 3'd0;
`endif
        end else begin
            state_reg <= state_next;
            min_reg   <= min_next;
            dez_reg   <= dez_next;
            seg_reg   <= seg_next;
            presc_reg <= presc_next;
`ifdef CONTADOR_ALARME_EN
            alarme_reg    <= alarme_next;
            alarm_cnt_reg <= alarm_cnt_next;
`endif
        end
    end

    assign Minutos   = min_reg;
    assign DezenaSeg = dez_reg;
    assign Segundos  = seg_reg;
    assign Rodando   = (state_reg == CONTANDO);
    assign Zero      = (state_reg == FIM);
`ifdef CONTADOR_ALARME_EN
    assign Alarme    = alarme_reg;
`else
    assign Alarme    = 1'b0;
`endif

endmodule

// File: tb/tb_contador_regressivo.sv
// Directed bench for contador_regressivo with DIV_TICK=4; alarm checks follow CONTADOR_ALARME_EN.
module tb_contador_regressivo;

    logic       clk = 1'b0;
    logic       reset, Start, Stop, Load;
    logic [3:0] LoadMin, LoadDez, LoadSeg;
    logic [3:0] Minutos, DezenaSeg, Segundos;
    logic       Rodando, Zero, Alarme;
    int         checks = 0;
    int         errors = 0;
    logic       alarm_exp;

    contador_regressivo #(.DIV_TICK(4)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Stop(Stop), .Load(Load),
        .LoadMin(LoadMin), .LoadDez(LoadDez), .LoadSeg(LoadSeg),
        .Minutos(Minutos), .DezenaSeg(DezenaSeg), .Segundos(Segundos),
        .Rodando(Rodando), .Zero(Zero), .Alarme(Alarme)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    function automatic logic [11:0] digits();
        return {Minutos, DezenaSeg, Segundos};
    endfunction

    function automatic logic [11:0] flags();
        return {9'd0, Rodando, Zero, Alarme};
    endfunction

    task automatic load_time(input logic [3:0] m, input logic [3:0] d, input logic [3:0] s);
        LoadMin = m; LoadDez = d; LoadSeg = s; Load = 1'b1;
        step(1);
        Load = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step(1);
        Start = 1'b0;
    endtask

    initial begin
`ifdef CONTADOR_ALARME_EN
        alarm_exp = 1'b1;
`else
        alarm_exp = 1'b0;
`endif
        reset = 1'b1; Start = 1'b0; Stop = 1'b0; Load = 1'b0;
        LoadMin = 4'd0; LoadDez = 4'd0; LoadSeg = 4'd0;
        step(2);
        reset = 1'b0;
        check("reset_digits", digits(), 12'h000);
        check("reset_flags", flags(), 12'h000);

        // 1:00 -> 0:59 after four counting cycles
        load_time(4'd1, 4'd0, 4'd0);
        check("load_100", digits(), 12'h100);
        pulse_start();
        check("start_rodando", flags(), 12'h004);
        step(3);
        check("before_tick_100", digits(), 12'h100);
        step(1);
        check("tick_059", digits(), 12'h059);
        check("tick_rodando", flags(), 12'h004);
        Stop = 1'b1; step(2); Stop = 1'b0;
        check("stop_twice_clear", digits(), 12'h000);

        // 0:02 expiry
        load_time(4'd0, 4'd0, 4'd2);
        pulse_start();
        step(4);
        check("exp_001", digits(), 12'h001);
        step(3);
        check("exp_hold_001", digits(), 12'h001);
        step(1);
        check("exp_000", digits(), 12'h000);
        check("exp_flags", flags(), {9'd0, 1'b0, 1'b1, alarm_exp});
        step(19);
        check("alarm_last_cycle", flags(), {9'd0, 1'b0, 1'b1, alarm_exp});
        step(1);
        check("alarm_off", flags(), 12'h002);
        check("exp_hold_000", digits(), 12'h000);
        pulse_start();
        check("start_in_fim", flags(), 12'h002);

        // pause/resume keeps prescaler phase
        load_time(4'd0, 4'd0, 4'd5);
        check("load_from_fim", flags(), 12'h000);
        pulse_start();
        step(6);
        check("run_004", digits(), 12'h004);
        Stop = 1'b1; step(1); Stop = 1'b0;
        check("paused_flags", flags(), 12'h000);
        step(3);
        check("paused_004", digits(), 12'h004);
        pulse_start();
        check("resume_004", digits(), 12'h004);
        step(1);
        check("resume_hold_004", digits(), 12'h004);
        step(1);
        check("resume_003", digits(), 12'h003);
        Stop = 1'b1; step(1);
        check("pause_003", digits(), 12'h003);
        step(1); Stop = 1'b0;
        check("stop2_000", digits(), 12'h000);

        // clamping and Load ignored while counting
        load_time(4'd12, 4'd7, 4'd15);
        check("clamp_959", digits(), 12'h959);
        pulse_start();
        LoadMin = 4'd1; LoadDez = 4'd1; LoadSeg = 4'd1; Load = 1'b1;
        step(2); Load = 1'b0;
        check("load_ignored", digits(), 12'h959);
        check("load_ignored_run", flags(), 12'h004);
        Stop = 1'b1; step(2); Stop = 1'b0;

        // start at 0:00 ignored
        pulse_start();
        check("start_zero", flags(), 12'h000);

        // tens borrow, then command priorities
        load_time(4'd0, 4'd1, 4'd0);
        pulse_start();
        step(4);
        check("borrow_009", digits(), 12'h009);
        Stop = 1'b1; Start = 1'b1; step(1); Stop = 1'b0; Start = 1'b0;
        check("stop_beats_start", flags(), 12'h000);
        check("stop_beats_start_d", digits(), 12'h009);
        LoadMin = 4'd0; LoadDez = 4'd3; LoadSeg = 4'd0; Load = 1'b1; Start = 1'b1;
        step(1); Load = 1'b0; Start = 1'b0;
        check("load_beats_start", digits(), 12'h030);
        check("load_beats_start_f", flags(), 12'h000);

        // reset mid-count
        load_time(4'd3, 4'd2, 4'd7);
        pulse_start();
        step(2);
        reset = 1'b1; Start = 1'b1; Load = 1'b1;
        step(1);
        reset = 1'b0; Start = 1'b0; Load = 1'b0;
        check("midreset_digits", digits(), 12'h000);
        check("midreset_flags", flags(), 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_regressivo.md
# contador_regressivo

BCD countdown timer (M:SS, 0:00–9:59) that produces the three digit nibbles consumed by the seven-segment decoder stage of the timer project. It divides the system clock into a one-second tick, decrements the loaded time while running, and flags expiry. Outputs are registered and feed the decoder's minute, tens-of-seconds and seconds inputs directly.

## Interface
- DIV_TICK, 50_000_000: clock cycles per count step (1 s at 50 MHz); minimum 2.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  level-sampled; begin or resume counting.
- Stop  input  1  level-sampled; pause, or clear when already paused.
- Load  input  1  level-sampled; capture LoadMin/LoadDez/LoadSeg.
- LoadMin  input  4  minutes digit to load (BCD).
- LoadDez  input  4  tens-of-seconds digit to load (BCD).
- LoadSeg  input  4  seconds digit to load (BCD).
- Minutos  output  4  current minutes digit, 0–9.
- DezenaSeg  output  4  current tens-of-seconds digit, 0–5.
- Segundos  output  4  current seconds digit, 0–9.
- Rodando  output  1  high while in CONTANDO.
- Zero  output  1  high while in FIM.
- Alarme  output  1  expiry indicator (see Configuration).

## Operation
- States: PARADO, CONTANDO, PAUSADO, FIM. Reset → PARADO, digits 0:00, prescaler 0, all flags 0.
- Command priority per cycle: Load > Stop > Start.
- Load accepted in PARADO, PAUSADO, FIM; ignored in CONTANDO. Next state PARADO; prescaler cleared. Clamping: LoadMin/LoadSeg >9 → 9; LoadDez >5 → 5.
- Start: PARADO or PAUSADO with time ≠ 0:00 → CONTANDO. Start with 0:00 ignored. Start in FIM ignored (Load required).
- Stop: CONTANDO → PAUSADO (digits and prescaler held). PAUSADO → PARADO with digits cleared to 0:00. FIM → PARADO, digits stay 0:00. PARADO: no effect.
- Prescaler counts 0..DIV_TICK-1 only in CONTANDO; Tick is internal, one cycle, when prescaler = DIV_TICK-1, then wraps to 0.
- Decrement on Tick: Segundos>0 → Segundos-1; else Segundos=9 and (DezenaSeg>0 → DezenaSeg-1; else DezenaSeg=5, Minutos-1).
- When the decrement result is 0:00, next state FIM on the same edge; digits never wrap below 0:00.
- Rodando = (state==CONTANDO); Zero = (state==FIM); both registered with state.

## Timing
- All outputs change only on the rising edge of clk; no combinational input-to-output paths.
- Load: digits visible on the edge after Load is sampled high.
- Start from PARADO: first decrement after exactly DIV_TICK cycles in CONTANDO.
- Resume from PAUSADO: remaining prescaler count preserved; decrement after DIV_TICK minus already-elapsed cycles.
- Expiry: the edge that writes 0:00 also sets Zero=1, Rodando=0.
- Reset mid-count: next edge returns to PARADO, 0:00, regardless of other inputs.
- Simultaneous Stop and Start in CONTANDO: Stop wins → PAUSADO. Load and Start in PAUSADO: Load wins → PARADO.

## Configuration
- CONTADOR_ALARME_EN defined: on entering FIM, Alarme goes high for 5 × DIV_TICK cycles (prescaler keeps running in FIM for this purpose), then low; cleared immediately by Load, Stop or reset.
- Undefined: Alarme tied to 0; prescaler idle in FIM.

## Test plan
- DIV_TICK=4; reset, Load 1:00, Start → after 4 cycles digits 0:59, Rodando=1.
- Load 0:02, Start → 0:01 after 4 cycles, 0:00 after 8; Zero=1, Rodando=0 on same edge; further cycles hold 0:00.
- Load 0:05, Start, Stop after 6 cycles → PAUSADO at 0:04, prescaler held; Start → 0:03 exactly 2 cycles later; Stop twice → 0:00, PARADO.
- Load LoadMin=12, LoadDez=7, LoadSeg=15 → 9:59; Load during CONTANDO → digits unchanged.
- Start with 0:00 → Rodando stays 0; reset asserted mid-count at 3:27 → 0:00, all flags 0 next edge.
- With CONTADOR_ALARME_EN: Load 0:01, Start → Zero=1 and Alarme=1 for 20 cycles, then Alarme=0; without macro Alarme=0 throughout.
